jstk_poll_scheduler: RTL and testbench

- Sequences one shared SPI transaction engine between the two JSTK2 joysticks (X channel, Y channel).
- Runs a fixed-rate poll: X first, then Y, once per poll period; decodes each 5-byte reply and holds the latest axis value and bumper per channel.
- Detects hung transactions by timeout and substitutes a safe centre value after repeated failures.
- Feeds the Backtrack/Sensor_Ctrl path in place of the two independent SPI interfaces.

---
 rtl/jstk_poll_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_jstk_poll_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/jstk_poll_scheduler.sv
// Shares one SPI transaction engine between the X and Y JSTK2 joysticks.
// Polls X then Y once per poll period, decodes each 5-byte reply, and
// substitutes a centred value on a channel after repeated timeouts.
module jstk_poll_scheduler #(
    parameter int unsigned POLL_CYCLES    = 100000,
    parameter int unsigned TIMEOUT_CYCLES = 40000,
    parameter int unsigned GAP_CYCLES     = 1500,
    parameter int unsigned FAIL_LIMIT     = 3
) (
    input  logic        clk,
    input  logic        rst,
    output logic        spi_start,
    output logic        spi_sel,
    input  logic        spi_busy,
    input  logic        spi_done,
    input  logic [39:0] spi_rx,
    output logic [10:0] x_val,
    output logic [10:0] y_val,
    output logic        x_bumper,
    output logic        y_bumper,
    output logic        x_upd,
    output logic        y_upd,
    output logic        x_fault,
    output logic        y_fault
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int unsigned POLL_W  = $clog2(POLL_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned FAIL_W  = $clog2(FAIL_LIMIT + 1);

    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(FAIL_LIMIT - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(FAIL_LIMIT);
    localparam logic [10:0]       CENTRE    = 11'd512;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DECODE,
        S_FAIL,
        S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [POLL_W-1:0]   poll_q;
    logic                tick;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sel_q, sel_d;
    logic [9:0]          raw_q, raw_d;
    logic                bump_q, bump_d;
    logic [10:0]         x_val_q, x_val_d, y_val_q, y_val_d;
    logic                x_bump_q, x_bump_d, y_bump_q, y_bump_d;
    logic                x_upd_q, x_upd_d, y_upd_q, y_upd_d;
    logic                x_fault_q, x_fault_d, y_fault_q, y_fault_d;
    logic [FAIL_W-1:0]   x_fail_q, x_fail_d, y_fail_q, y_fail_d;

    // Reply bytes that carry nothing this block uses.
    logic rx_unused;
    assign rx_unused = ^{spi_rx[31:26], spi_rx[15:10], spi_rx[7:1]};

    assign tick = (poll_q == POLL_LAST);

    // Free-running poll-period timer; tick marks its last count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            poll_q <= '0;
        end else if (tick) begin
            poll_q <= '0;
        end else begin
            poll_q <= poll_q + 1'b1;
        end
    end

    // State, counters, captured reply and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sel_q     <= 1'b0;
            raw_q     <= '0;
            bump_q    <= 1'b0;
            x_val_q   <= CENTRE;
            y_val_q   <= CENTRE;
            x_bump_q  <= 1'b0;
            y_bump_q  <= 1'b0;
            x_upd_q   <= 1'b0;
            y_upd_q   <= 1'b0;
            x_fault_q <= 1'b0;
            y_fault_q <= 1'b0;
            x_fail_q  <= '0;
            y_fail_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            raw_q     <= raw_d;
            bump_q    <= bump_d;
            x_val_q   <= x_val_d;
            y_val_q   <= y_val_d;
            x_bump_q  <= x_bump_d;
            y_bump_q  <= y_bump_d;
            x_upd_q   <= x_upd_d;
            y_upd_q   <= y_upd_d;
            x_fault_q <= x_fault_d;
            y_fault_q <= y_fault_d;
            x_fail_q  <= x_fail_d;
            y_fail_q  <= y_fail_d;
        end
    end

    // Next-state logic: launch, wait/timeout, decode or fail, then gap.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        raw_d     = raw_q;
        bump_d    = bump_q;
        x_val_d   = x_val_q;
        y_val_d   = y_val_q;
        x_bump_d  = x_bump_q;
        y_bump_d  = y_bump_q;
        x_upd_d   = 1'b0;
        y_upd_d   = 1'b0;
        x_fault_d = x_fault_q;
        y_fault_d = y_fault_q;
        x_fail_d  = x_fail_q;
        y_fail_d  = y_fail_q;
        spi_start = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    sel_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (!spi_busy) begin
                    spi_start = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                // done wins over the timeout expiring in the same cycle
                if (spi_done) begin
                    raw_d   = sel_q ? {spi_rx[9:8], spi_rx[23:16]}
                                    : {spi_rx[25:24], spi_rx[39:32]};
                    bump_d  = spi_rx[0];
                    state_d = S_DECODE;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_FAIL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (!sel_q) begin
                    x_val_d   = {1'b0, raw_q};
                    x_bump_d  = bump_q;
                    x_upd_d   = 1'b1;
                    x_fail_d  = '0;
                    x_fault_d = 1'b0;
                end else begin
                    y_val_d   = {1'b0, raw_q};
                    y_bump_d  = bump_q;
                    y_upd_d   = 1'b1;
                    y_fail_d  = '0;
                    y_fault_d = 1'b0;
                end
                cnt_d   = '0;
                state_d = S_GAP;
            end
            S_FAIL: begin
                if (!sel_q) begin
                    if (x_fail_q >= FAIL_LAST) begin
                        x_fail_d  = FAIL_MAX;
                        x_fault_d = 1'b1;
                        x_val_d   = CENTRE;
                        x_bump_d  = 1'b0;
                        x_upd_d   = 1'b1;
                    end else begin
                        x_fail_d = x_fail_q + 1'b1;
                    end
                end else begin
                    if (y_fail_q >= FAIL_LAST) begin
                        y_fail_d  = FAIL_MAX;
                        y_fault_d = 1'b1;
                        y_val_d   = CENTRE;
                        y_bump_d  = 1'b0;
                        y_upd_d   = 1'b1;
                    end else begin
                        y_fail_d = y_fail_q + 1'b1;
                    end
                end
                cnt_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    if (!sel_q) begin
                        sel_d   = 1'b1;
                        state_d = S_START;
                    end else begin
                        sel_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign spi_sel  = sel_q;
    assign x_val    = x_val_q;
    assign y_val    = y_val_q;
    assign x_bumper = x_bump_q;
    assign y_bumper = y_bump_q;
    assign x_upd    = x_upd_q;
    assign y_upd    = y_upd_q;
    assign x_fault  = x_fault_q;
    assign y_fault  = y_fault_q;

endmodule

// File: tb/tb_jstk_poll_scheduler.sv
// Directed bench for jstk_poll_scheduler with shortened timing parameters.
module tb_jstk_poll_scheduler;

    localparam int POLL = 300;
    localparam int TMO  = 40;
    localparam int GAP  = 10;
    localparam int FL   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        spi_start, spi_sel;
    logic        spi_busy = 1'b0;
    logic        spi_done = 1'b0;
    logic [39:0] spi_rx = '0;
    logic [10:0] x_val, y_val;
    logic        x_bumper, y_bumper, x_upd, y_upd, x_fault, y_fault;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    jstk_poll_scheduler #(
        .POLL_CYCLES   (POLL),
        .TIMEOUT_CYCLES(TMO),
        .GAP_CYCLES    (GAP),
        .FAIL_LIMIT    (FL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .spi_start(spi_start),
        .spi_sel  (spi_sel),
        .spi_busy (spi_busy),
        .spi_done (spi_done),
        .spi_rx   (spi_rx),
        .x_val    (x_val),
        .y_val    (y_val),
        .x_bumper (x_bumper),
        .y_bumper (y_bumper),
        .x_upd    (x_upd),
        .y_upd    (y_upd),
        .x_fault  (x_fault),
        .y_fault  (y_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a spi_start pulse; n is the number of negedges waited.
    task automatic wait_start(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (spi_start !== 1'b1 && n < 2 * POLL);
        check(tag, 32'(spi_start), 32'd1);
    endtask

    // Called at a negedge while in WAIT-bound flow; returns at the negedge
    // where the decoded outputs become visible.
    task automatic respond(input int d, input logic [39:0] rx);
        repeat (d) @(negedge clk);
        spi_rx   = rx;
        spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int c_a, c_b, nst;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_x_val", 32'(x_val), 32'd512);
        check("rst_y_val", 32'(y_val), 32'd512);
        check("rst_x_fault", 32'(x_fault), 32'd0);
        check("rst_y_fault", 32'(y_fault), 32'd0);
        check("rst_start", 32'(spi_start), 32'd0);
        check("rst_sel", 32'(spi_sel), 32'd0);
        check("rst_upd", 32'({x_upd, y_upd}), 32'd0);
        rst = 1'b1;

        // Poll A: first start lands exactly one poll period after reset
        wait_start("a_x_start", n);
        check("a_first_start_cycle", 32'(n), 32'(POLL));
        check("a_x_sel", 32'(spi_sel), 32'd0);
        c_a = cyc;
        respond(3, 40'h3F_02_00_00_01);
        check("a_x_val", 32'(x_val), 32'd575);
        check("a_x_bumper", 32'(x_bumper), 32'd1);
        check("a_x_upd", 32'(x_upd), 32'd1);
        check("a_y_upd_quiet", 32'(y_upd), 32'd0);
        @(negedge clk);
        check("a_x_upd_single", 32'(x_upd), 32'd0);
        wait_start("a_y_start", n);
        check("a_y_sel", 32'(spi_sel), 32'd1);
        respond(2, 40'h00_00_A5_03_00);
        check("a_y_val", 32'(y_val), 32'd933);
        check("a_y_bumper", 32'(y_bumper), 32'd0);
        check("a_y_upd", 32'(y_upd), 32'd1);
        check("a_x_upd_quiet", 32'(x_upd), 32'd0);
        check("a_x_val_kept", 32'(x_val), 32'd575);

        // Poll B: period check, upper reply bits ignored
        wait_start("b_x_start", n);
        check("b_period", 32'(cyc - c_a), 32'(POLL));
        c_b = cyc;
        respond(3, 40'h10_FD_00_00_00);
        check("b_x_val", 32'(x_val), 32'd272);
        check("b_x_bumper", 32'(x_bumper), 32'd0);
        wait_start("b_y_start", n);
        respond(3, 40'h00_00_FF_FE_01);
        check("b_y_val", 32'(y_val), 32'd767);
        check("b_y_bumper", 32'(y_bumper), 32'd1);

        // Poll C: engine busy for 200 cycles at START
        spi_busy = 1'b1;
        nst = 0;
        while (cyc < c_b + POLL + 200) begin
            @(negedge clk);
            if (spi_start === 1'b1) nst++;
        end
        check("c_no_start_while_busy", 32'(nst), 32'd0);
        spi_busy = 1'b0;
        #1;
        check("c_start_on_busy_drop", 32'(spi_start), 32'd1);
        @(negedge clk);
        check("c_start_one_pulse", 32'(spi_start), 32'd0);
        respond(0, 40'h80_01_00_00_01);
        check("c_x_val", 32'(x_val), 32'd384);
        check("c_x_bumper", 32'(x_bumper), 32'd1);
        wait_start("c_y_start", n);
        respond(3, 40'h00_00_07_01_01);
        check("c_y_val", 32'(y_val), 32'd263);

        // Poll D: X timeout #1, then a late done in GAP is ignored
        wait_start("d_x_start", n);
        repeat (TMO + 2) @(negedge clk);
        check("d_x_hold_val", 32'(x_val), 32'd384);
        check("d_x_no_upd", 32'(x_upd), 32'd0);
        check("d_x_no_fault", 32'(x_fault), 32'd0);
        spi_rx   = 40'h55_01_00_00_00;
        spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
        check("d_gap_done_no_upd0", 32'(x_upd), 32'd0);
        @(negedge clk);
        check("d_gap_done_no_upd1", 32'(x_upd), 32'd0);
        check("d_gap_done_val", 32'(x_val), 32'd384);
        wait_start("d_y_start", n);
        check("d_y_sel", 32'(spi_sel), 32'd1);
        respond(4, 40'h00_00_00_00_00);
        check("d_y_val", 32'(y_val), 32'd0);

        // Poll E: X timeout #2
        wait_start("e_x_start", n);
        repeat (TMO + 2) @(negedge clk);
        check("e_x_hold_val", 32'(x_val), 32'd384);
        check("e_x_no_fault", 32'(x_fault), 32'd0);
        wait_start("e_y_start", n);
        respond(3, 40'h00_00_01_00_01);
        check("e_y_val", 32'(y_val), 32'd1);

        // Poll F: X timeout #3 declares fault and centres X
        wait_start("f_x_start", n);
        repeat (TMO + 2) @(negedge clk);
        check("f_x_fault", 32'(x_fault), 32'd1);
        check("f_x_val_centre", 32'(x_val), 32'd512);
        check("f_x_bumper_clr", 32'(x_bumper), 32'd0);
        check("f_x_upd", 32'(x_upd), 32'd1);
        check("f_y_fault", 32'(y_fault), 32'd0);
        check("f_y_val_kept", 32'(y_val), 32'd1);
        wait_start("f_y_start", n);
        respond(3, 40'h00_00_FF_03_00);
        check("f_y_val", 32'(y_val), 32'd1023);
        check("f_y_fault_after", 32'(y_fault), 32'd0);

        // Poll G: done on the last timeout cycle counts as success
        wait_start("g_x_start", n);
        respond(TMO, 40'hFF_03_00_00_01);
        check("g_x_val", 32'(x_val), 32'd1023);
        check("g_x_bumper", 32'(x_bumper), 32'd1);
        check("g_x_fault_clr", 32'(x_fault), 32'd0);
        check("g_x_upd", 32'(x_upd), 32'd1);
        wait_start("g_y_start", n);
        respond(1, 40'h00_00_2A_01_01);
        check("g_y_val", 32'(y_val), 32'd298);

        // Poll H: reset during the Y transfer
        wait_start("h_x_start", n);
        respond(2, 40'h3F_02_00_00_01);
        check("h_x_val", 32'(x_val), 32'd575);
        wait_start("h_y_start", n);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("h_rst_x_val", 32'(x_val), 32'd512);
        check("h_rst_y_val", 32'(y_val), 32'd512);
        check("h_rst_sel", 32'(spi_sel), 32'd0);
        check("h_rst_bumpers", 32'({x_bumper, y_bumper}), 32'd0);
        check("h_rst_start", 32'(spi_start), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_start("h_restart", n);
        check("h_restart_cycle", 32'(n), 32'(POLL));
        check("h_restart_sel", 32'(spi_sel), 32'd0);
        respond(3, 40'h10_FD_00_00_00);
        check("h_x_val_after", 32'(x_val), 32'd272);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
